serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial add scheduler that shares one half-adder-based 1-bit add cell between two requesters. It arbitrates round-robin between the requesters, captures the winner's W-bit operands, and runs one bit per clock through the shared cell (two half adders plus carry register). It then returns a W-bit sum and carry-out tagged with the owner. It sits between the bit-level adder cells and any block that needs occasional multi-bit adds without paying for a parallel adder.

## Interface
- W, 8, operand/sum width in bits; W >= 1.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 add request; level.
- a0, b0  in  W  requester 0 operands; sampled only on the granting edge.
- req1  in  1  requester 1 add request; level.
- a1, b1  in  W  requester 1 operands; sampled only on the granting edge.
- gnt0, gnt1  out  1  one-cycle pulse: operands of that requester were captured.
- busy  out  1  high while an add is in progress (state != IDLE).
- done  out  1  one-cycle pulse: sum/cout/owner updated.
- owner  out  1  requester index of the current sum/cout.
- sum  out  W  result, LSB-aligned; held until the next done.
- cout  out  1  carry out of bit W-1; held until the next done.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE:** if req0 or req1 is high on an edge, the block:
  - picks the winner;
  - loads the winner's a/b into the operand shift registers;
  - clears the carry register and bit counter;
  - registers gnt for the winner;
  - moves to RUN.
- With no request, the block stays in IDLE.
- **Arbitration:** a priority pointer ptr (reset 0) names the preferred requester.
  - Both requesting: grant ptr.
  - One requesting: grant it.
  - After any grant, ptr <= the index of the requester that was not granted.
  - Result: strict alternation under continuous contention, and no starvation.
- **RUN:** each edge processes the operand LSBs a, b with carry c:
  - half adder 1: p = a^b, g = a&b;
  - half adder 2: s = p^c, t = p&c;
  - c <= g|t.
  - s shifts into the MSB of the sum shift register; the operand registers shift right.
  - The counter increments, and the edge processing bit W-1 moves the FSM to DONE.
- **Entering DONE:** on the same edge, the block loads sum, cout (the final carry) and owner, and registers done=1.
- **DONE:** lasts one cycle, then returns to IDLE. done returns to 0.
- **Operands:** changing a/b after gnt has no effect on the add.
- **Requests:** a req still high when the FSM is next in IDLE is treated as a new request. A requester drops req in the cycle it sees its gnt if it wants only one add.
- **Reset:** rst on any edge, including mid-RUN, aborts the add.
  - The FSM returns to IDLE and ptr returns to 0.
  - All outputs clear: gnt0=gnt1=busy=done=owner=cout=0, sum=0.
  - No done is issued for the aborted add.
  - rst has priority over every other event.

## Timing
- **Numbering:** edge 0 is the IDLE edge that samples a request.
- **Grant:** gnt visible in the cycle after edge 0, for exactly one cycle.
- **Busy:** busy rises after edge 0.
- **Run edges:** bits 0..W-1 are processed on edges 1..W.
- **Result:** done=1 and sum/cout/owner update in the cycle after edge W. Latency from request sample to result is W edges.
- **Return to idle:** edge W+1 enters IDLE and busy falls. Edge W+2 can sample the next request.
- **Throughput:** one add per W+2 cycles.
- gnt0 and gnt1 are never high in the same cycle, and at most one gnt is issued per add.
- sum, cout and owner change only on the edge that raises done, or on rst.

## Test plan
- **Single add, W=8:** req0 with a0=8'hFF, b0=8'h01 -> gnt0 pulses after edge 0, done after edge 8 with sum=8'h00, cout=1, owner=0; busy is low after edge 9.
- **Simultaneous requests after reset:** req0 (3+4) and req1 (10+20) together -> requester 0 served first (sum=7, owner=0), then requester 1 (sum=30, owner=1) starting at edge 10; gnt pulses never overlap.
- **Continuous contention:** req0 and req1 held high for 6 adds -> owner sequence 0,1,0,1,0,1 and done every 10 cycles.
- **Reset mid-operation:** rst on edge 4 of an add -> no done; all outputs 0 next cycle. A subsequent simultaneous request is granted to requester 0.
- **Operand hold-off:** change a0/b0 every cycle after gnt0 -> result equals the values captured at the grant.
- **Randomized check:** random operands and requests at W=8 and W=1 -> every done matches {cout,sum} == a+b of the owner's captured operands.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Round-robin scheduler sharing one bit-serial add cell (two half adders plus a
// carry register) between two requesters; returns a W-bit sum and carry tagged with the owner.
module serial_add_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         owner,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic           ptr_r;
  logic           cur_r;
  logic           c_r;
  logic [CW-1:0]  cnt_r;
  logic [W-1:0]   a_sh_r;
  logic [W-1:0]   b_sh_r;
  logic [W-1:0]   a_next_s;
  logic           any_req_s;
  logic           win1_s;
  logic           last_bit_s;
  logic           p_s;
  logic           g_s;
  logic           s_s;
  logic           t_s;
  logic           c_next_s;

  // Shared add cell: half adder 1 on the operand LSBs, half adder 2 folds in the carry.
  always_comb begin
    p_s      = a_sh_r[0] ^ b_sh_r[0];
    g_s      = a_sh_r[0] & b_sh_r[0];
    s_s      = p_s ^ c_r;
    t_s      = p_s & c_r;
    c_next_s = g_s | t_s;
  end

  // Sum bits enter the MSB vacated by the right-shifting a operand, so after W
  // shifts a_sh_r holds the LSB-aligned sum.
  if (W == 1) begin : g_w1
    assign a_next_s = s_s;
  end else begin : g_wn
    assign a_next_s = {s_s, a_sh_r[W-1:1]};
  end

  // Arbitration: both requesting -> pointer wins, otherwise the lone requester.
  always_comb begin
    any_req_s  = req0 | req1;
    last_bit_s = (cnt_r == LAST);
    if (req0 && req1) begin
      win1_s = ptr_r;
    end else if (req1) begin
      win1_s = 1'b1;
    end else begin
      win1_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath, arbitration pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r  <= 1'b0;
      cur_r  <= 1'b0;
      c_r    <= 1'b0;
      cnt_r  <= '0;
      a_sh_r <= '0;
      b_sh_r <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      owner  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            a_sh_r <= win1_s ? a1 : a0;
            b_sh_r <= win1_s ? b1 : b0;
            c_r    <= 1'b0;
            cnt_r  <= '0;
            cur_r  <= win1_s;
            ptr_r  <= ~win1_s;
            gnt0   <= ~win1_s;
            gnt1   <= win1_s;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          a_sh_r <= a_next_s;
          b_sh_r <= b_sh_r >> 1'b1;
          c_r    <= c_next_s;
          cnt_r  <= cnt_r + CW'(1);
          if (last_bit_s) begin
            sum   <= a_next_s;
            cout  <= c_next_s;
            owner <= cur_r;
            done  <= 1'b1;
          end
        end
        DONE: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
